// File: rtl/lfsr.sv
// Free-running maximal-length Fibonacci LFSR, shifting left with feedback into the LSB.
// Width 2..32; taps come from an internal maximal-length polynomial table indexed by N.
module lfsr #(
    parameter int           N    = 4,
    parameter logic [N-1:0] SEED = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic [N-1:0] data_o
);

    generate
        if (N < 2 || N > 32) begin : g_bad_width
            $error("lfsr: N must be in 2..32");
        end
    endgenerate

    // Bit k-1 set for tap k of the maximal-length polynomial of width n.
    function automatic logic [31:0] tap_mask(input int n);
        case (n)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    localparam logic [31:0]  TAP_MASK  = tap_mask(N);
    // A zero seed would lock the register up, so it is replaced by 1.
    localparam logic [N-1:0] RESET_VAL = (SEED == '0) ? N'(1) : SEED;

    logic [N-1:0] r_state;
    logic [N-1:0] w_tapped;
    logic         w_fb;
    logic [N-1:0] w_state_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_tap
            assign w_tapped[gi] = r_state[gi] & TAP_MASK[gi];
        end
    endgenerate

    assign w_fb = ^w_tapped;

    // The all-zero state cannot be reached normally; recover from it anyway.
    always_comb begin
        w_state_next = {r_state[N-2:0], w_fb};
        if (r_state == '0) begin
            w_state_next = N'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RESET_VAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign data_o = r_state;

endmodule

// File: tb/tb_lfsr.sv
// Bench for lfsr: scoreboarded N=4 sequence with random resets, plus period,
// seed and lock-up recovery checks on several widths.
`timescale 1ns/100ps
module tb_lfsr;

    logic clk = 1'b0;
    always #2.5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // N=4 device under scoreboard
    logic       rst4 = 1'b0;
    logic [3:0] d4;
    lfsr #(.N(4), .SEED(4'd1)) dut4 (.clk_i(clk), .rst_i(rst4), .data_o(d4));

    // Period / seed devices share one reset
    logic        rstb = 1'b0;
    logic [7:0]  d8, d8a5, d8z;
    logic [15:0] d16;
    logic [1:0]  d2;
    lfsr #(.N(8),  .SEED(8'd1))   dut8   (.clk_i(clk), .rst_i(rstb), .data_o(d8));
    lfsr #(.N(8),  .SEED(8'hA5))  dut8a5 (.clk_i(clk), .rst_i(rstb), .data_o(d8a5));
    lfsr #(.N(8),  .SEED(8'h00))  dut8z  (.clk_i(clk), .rst_i(rstb), .data_o(d8z));
    lfsr #(.N(16), .SEED(16'd1))  dut16  (.clk_i(clk), .rst_i(rstb), .data_o(d16));
    lfsr #(.N(2),  .SEED(2'd1))   dut2   (.clk_i(clk), .rst_i(rstb), .data_o(d2));

    // Reference sequence for N=4, SEED=1, as a plain lookup table
    logic [3:0] seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                             4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    int         idx = 0;
    logic [3:0] exp_q [$];
    int         cyc4 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One stimulus step: set reset for the coming edge and queue the expected state
    task automatic drive4(input bit rst);
        @(negedge clk);
        rst4 = rst;
        if (rst) idx = 0;
        else     idx = (idx + 1) % 15;
        exp_q.push_back(seq[idx]);
    endtask

    // Monitor: one comparison per clock whenever a response is outstanding
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [3:0] e;
                e = exp_q.pop_front();
                cyc4++;
                $display("[TB] n4 cycle %0d rst=%0b data_o=%0h exp=%0h", cyc4, rst4, d4, e);
                check("n4_seq", 32'(d4), 32'(e));
            end
        end
    end

    task automatic run_n4();
        bit did_b = 0;
        bit r;
        drive4(1);
        repeat (30) drive4(0);
        repeat (5)  drive4(1);
        repeat (20) drive4(0);
        for (int i = 0; i < 1024; i++) begin
            r = ($urandom_range(0, 99) == 0);
            if (!did_b && seq[idx] == 4'hB) begin
                r = 1;
                did_b = 1;
            end
            drive4(r);
        end
        @(negedge clk);
        rst4 = 1'b0;
    endtask

    task automatic run_period();
        bit seen8 [256];
        bit seen16 [65536];
        bit seen2 [4];
        int dup8 = 0, dup16 = 0, dup2 = 0;
        @(negedge clk);
        rstb = 1'b1;
        @(posedge clk);
        #1;
        check("a5_reset", 32'(d8a5), 32'hA5);
        check("seed0_reset", 32'(d8z), 32'h1);
        check("n16_reset", 32'(d16), 32'h1);
        @(negedge clk);
        rstb = 1'b0;
        for (int s = 1; s <= 65535; s++) begin
            @(posedge clk);
            #1;
            if (s == 1) begin
                check("a5_step1", 32'(d8a5), 32'h4A);
                check("seed0_step1", 32'(d8z), 32'h2);
            end
            if (s <= 3) begin
                if (d2 == 0 || seen2[d2]) dup2++;
                seen2[d2] = 1;
                if (s == 3) begin
                    $display("[TB] n2 period end data_o=%0h", d2);
                    check("n2_period", 32'(d2), 32'h1);
                    check("n2_distinct", 32'(dup2), 32'h0);
                end
            end
            if (s <= 255) begin
                if (d8 == 0 || seen8[d8]) dup8++;
                seen8[d8] = 1;
                if (s == 255) begin
                    $display("[TB] n8 period end data_o=%0h", d8);
                    check("n8_period", 32'(d8), 32'h1);
                    check("n8_distinct", 32'(dup8), 32'h0);
                end
            end
            if (d16 == 0 || seen16[d16]) dup16++;
            seen16[d16] = 1;
        end
        $display("[TB] n16 period end data_o=%0h", d16);
        check("n16_period", 32'(d16), 32'h1);
        check("n16_distinct", 32'(dup16), 32'h0);
    endtask

    initial begin
        fork
            run_n4();
            run_period();
        join
        // Scoreboard must have drained
        repeat (2) @(posedge clk);
        check("n4_queue_empty", 32'(exp_q.size()), 32'h0);
        check("n4_cycles_seen", 32'(cyc4), 32'(1 + 30 + 5 + 20 + 1024));

        // Lock-up recovery: deposit zero, next edge must give 1
        @(negedge clk);
        force dut4.r_state = 4'h0;
        #0.5;
        release dut4.r_state;
        @(posedge clk);
        #1;
        $display("[TB] lockup recovery data_o=%0h", d4);
        check("lockup_recover", 32'(d4), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
